pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards
//  between ID and EX, freezes the pipe while the dcache reports a miss, and flushes
//  IF/ID on taken branches. Drives PC write, IF/ID write/flush, ID/EX bubble and the
//  common stall_i of the ID/EX, EX/MEM and MEM/WB registers. Adds a watchdog on
//  dcache waits.
// PARAMETERS
//  REG_W     5    register-index width
//  WAIT_MAX  256  max consecutive dcache-stall cycles before timeout (>=2)
//  CNT_W     16   width of stall performance counter (STALL_CNT_EN only)
// PORTS
//  clk_i           in   1       clock, rising edge
//  rst_i           in   1       asynchronous reset, active high
//  id_rs_i         in   REG_W   rs field of instruction in ID
//  id_rt_i         in   REG_W   rt field of instruction in ID
//  ex_memread_i    in   1       MemRead of instruction in EX
//  ex_rt_i         in   REG_W   rt (load destination) of instruction in EX
//  dcache_stall_i  in   1       dcache miss in progress (level)
//  branch_taken_i  in   1       branch resolved taken in ID
//  pc_write_o      out  1       PC update enable
//  if_id_write_o   out  1       IF/ID load enable
//  if_id_flush_o   out  1       IF/ID clear to NOP
//  id_ex_bubble_o  out  1       zero ID/EX control inputs (insert NOP)
//  pipe_stall_o    out  1       hold ID/EX, EX/MEM, MEM/WB (their stall_i)
//  timeout_o       out  1       sticky dcache-wait timeout flag
//  stall_cnt_o     out  CNT_W   total stalled cycles (STALL_CNT_EN only)
// BEHAVIOUR
//  - State register {RUN, MEM_WAIT, ERR}; wait_cnt ($clog2(WAIT_MAX) bits).
//  - Outputs are combinational from state + inputs; state/counters update on clk_i.
//  - While rst_i=1: state=RUN, wait_cnt=0, timeout_o=0, stall_cnt_o=0; outputs
//    pc_write_o=0, if_id_write_o=0, if_id_flush_o=0, id_ex_bubble_o=1, pipe_stall_o=0.
//  - load_use = ex_memread_i & (ex_rt_i!=0) & (ex_rt_i==id_rs_i | ex_rt_i==id_rt_i).
//  - RUN, priority high->low:
//    1 dcache_stall_i=1: pipe_stall_o=1, pc_write_o=0, if_id_write_o=0, bubble=0,
//      flush=0; next MEM_WAIT, wait_cnt<=1.
//    2 load_use: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, pipe_stall_o=0,
//      flush=0 (branch_taken_i ignored; re-evaluated next cycle); stay RUN.
//    3 branch_taken_i: pc_write_o=1, if_id_write_o=1, if_id_flush_o=1.
//    4 else: pc_write_o=1, if_id_write_o=1, all others 0.
//  - MEM_WAIT: dcache_stall_i=1 -> same outputs as RUN case 1; wait_cnt++;
//    if wait_cnt==WAIT_MAX-1 -> ERR, timeout_o<=1. dcache_stall_i=0 -> outputs
//    evaluated exactly as RUN cases 2-4 in the same cycle; next RUN, wait_cnt<=0.
//  - ERR: pc_write_o=0, if_id_write_o=0, pipe_stall_o=1, flush=0, bubble=0;
//    timeout_o=1; exits only on rst_i (dcache_stall_i ignored).
//  - Total latency from dcache_stall_i rising to pipe_stall_o: 0 cycles.
//  - Load-use bubble lasts exactly one cycle (EX holds NOP next cycle, load_use=0).
//  - Reset mid-MEM_WAIT: immediate return to RUN, counters cleared asynchronously.
// CONFIGURATION
//  - PIPE_STALL_CNT_EN defined: stall_cnt_o present; increments by 1 on every cycle
//    with pc_write_o=0 and rst_i=0 (load-use, dcache wait, ERR); saturates at
//    2^CNT_W-1, never wraps.
//  - Undefined: stall_cnt_o port and counter absent; all else identical.
// TESTING
//  - Reset: rst_i=1 mid-run -> outputs at reset values same cycle; release -> RUN,
//    pc_write_o=1.
//  - Load-use: ex_memread_i=1, ex_rt_i=5, id_rt_i=5 -> 1 cycle pc_write_o=0,
//    id_ex_bubble_o=1; ex_rt_i=0 variant -> no bubble.
//  - Dcache miss: dcache_stall_i=1 for 10 cycles -> pipe_stall_o=1 those 10 cycles,
//    pc_write_o=1 on cycle 11, timeout_o=0.
//  - Branch: branch_taken_i=1, no hazard -> if_id_flush_o=1, pc_write_o=1; with
//    concurrent load_use -> flush=0, bubble=1.
//  - Simultaneous: dcache_stall_i=1 with load_use and branch -> only stall signals
//    asserted; on release load_use bubble appears in release cycle.
//  - Timeout (WAIT_MAX=8): dcache_stall_i held 20 cycles -> timeout_o=1 after 7th
//    stall cycle, stays ERR after stall drops until rst_i; with PIPE_STALL_CNT_EN,
//    CNT_W=4 -> stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubble, dcache freeze with watchdog, branch flush; outputs are same-cycle combinational.
// A held dcache_stall_i freezes the whole pipe; PIPE_STALL_CNT_EN adds a saturating stalled-cycle counter (stall_cnt_o).
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int WAIT_MAX = 256
`ifdef PIPE_STALL_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             dcache_stall_i,
  input  logic             branch_taken_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_stall_o,
  output logic             timeout_o
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int WC_W = $clog2(WAIT_MAX);
  // wait_cnt holds the count of stall cycles already seen, so the last legal
  // MEM_WAIT stall cycle is the one where it reads WAIT_MAX-2.
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 2);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic load_use;
  logic run_pc_write, run_if_id_write, run_flush, run_bubble;

  assign load_use = ex_memread_i && (ex_rt_i != '0) &&
                    ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

  // Hazard resolution when the dcache is not holding the pipe.
  always_comb begin
    run_pc_write    = 1'b1;
    run_if_id_write = 1'b1;
    run_flush       = 1'b0;
    run_bubble      = 1'b0;
    if (load_use) begin
      run_pc_write    = 1'b0;
      run_if_id_write = 1'b0;
      run_bubble      = 1'b1;
    end else if (branch_taken_i) begin
      run_flush = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    pc_write_o     = run_pc_write;
    if_id_write_o  = run_if_id_write;
    if_id_flush_o  = run_flush;
    id_ex_bubble_o = run_bubble;
    pipe_stall_o   = 1'b0;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (dcache_stall_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_bubble_o = 1'b0;
            pipe_stall_o   = 1'b1;
            state_d        = MEM_WAIT;
            wait_cnt_d     = WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dcache_stall_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_bubble_o = 1'b0;
            pipe_stall_o   = 1'b1;
            wait_cnt_d     = wait_cnt_q + WC_W'(1);
            if (wait_cnt_q >= WAIT_LAST) begin
              state_d   = ERR;
              timeout_d = 1'b1;
            end
          end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end
        end
        ERR: begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          if_id_flush_o  = 1'b0;
          id_ex_bubble_o = 1'b0;
          pipe_stall_o   = 1'b1;
        end
        default: begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (WAIT_MAX 256 and 8) against a rule-level reference model.
// Optional PIPE_STALL_CNT_EN build also checks the saturating stall counter.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       memread, dcache, branch;

  logic pc_a, ifw_a, fl_a, bub_a, ps_a, tmo_a;
  logic pc_b, ifw_b, fl_b, bub_b, ps_b, tmo_b;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W(5), .WAIT_MAX(256)
`ifdef PIPE_STALL_CNT_EN
    , .CNT_W(16)
`endif
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_memread_i(memread), .ex_rt_i(ex_rt), .dcache_stall_i(dcache),
    .branch_taken_i(branch), .pc_write_o(pc_a), .if_id_write_o(ifw_a),
    .if_id_flush_o(fl_a), .id_ex_bubble_o(bub_a), .pipe_stall_o(ps_a),
    .timeout_o(tmo_a)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt_o(cnt_a)
`endif
  );

  pipeline_hazard_ctrl #(
    .REG_W(5), .WAIT_MAX(8)
`ifdef PIPE_STALL_CNT_EN
    , .CNT_W(4)
`endif
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_memread_i(memread), .ex_rt_i(ex_rt), .dcache_stall_i(dcache),
    .branch_taken_i(branch), .pc_write_o(pc_b), .if_id_write_o(ifw_b),
    .if_id_flush_o(fl_b), .id_ex_bubble_o(bub_b), .pipe_stall_o(ps_b),
    .timeout_o(tmo_b)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt_o(cnt_b)
`endif
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  // Reference model: consecutive-stall run length, sticky error, stalled-cycle total.
  int n_m   [2];
  bit err_m [2];
  int cnt_m [2];
  int wmax  [2];
  int cmax  [2];

  typedef struct {
    bit         r;
    logic [4:0] rs, rt, xrt;
    bit         mr, dc, br;
    logic [4:0] e;  // {pc_write, if_id_write, flush, bubble, pipe_stall}
  } vec_t;
  vec_t tab [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit ref_lu();
    return memread && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  function automatic logic [4:0] ref_outs(bit r, bit e, bit dc, bit lu, bit br);
    if (r)       return 5'b00010;
    if (e || dc) return 5'b00001;
    if (lu)      return 5'b00010;
    if (br)      return 5'b11100;
    return 5'b11000;
  endfunction

  // One clock: check at the falling edge, advance the model, then move to just past the rising edge.
  // sel 1/2 additionally compares instance a/b against e5 and et.
  task automatic step(input int sel, input logic [4:0] e5, input logic et);
    logic [4:0] got [2];
    logic       tmo [2];
    logic [4:0] ex;
    @(negedge clk);
    got[0] = {pc_a, ifw_a, fl_a, bub_a, ps_a};
    got[1] = {pc_b, ifw_b, fl_b, bub_b, ps_b};
    tmo[0] = tmo_a;
    tmo[1] = tmo_b;
    for (int i = 0; i < 2; i++) begin
      ex = ref_outs(rst, err_m[i], dcache, ref_lu(), branch);
      chk($sformatf("model_outs[%0d]", i), 32'(got[i]), 32'(ex));
      chk($sformatf("model_timeout[%0d]", i), 32'(tmo[i]), (rst ? 32'd0 : 32'(err_m[i])));
    end
`ifdef PIPE_STALL_CNT_EN
    chk("model_stall_cnt[0]", 32'(cnt_a), (rst ? 32'd0 : 32'(cnt_m[0])));
    chk("model_stall_cnt[1]", 32'(cnt_b), (rst ? 32'd0 : 32'(cnt_m[1])));
`endif
    if (sel == 1 || sel == 2) begin
      chk($sformatf("vec_outs[%0d]", sel - 1), 32'(got[sel-1]), 32'(e5));
      chk($sformatf("vec_timeout[%0d]", sel - 1), 32'(tmo[sel-1]), 32'(et));
    end
    for (int i = 0; i < 2; i++) begin
      ex = ref_outs(rst, err_m[i], dcache, ref_lu(), branch);
      if (rst) begin
        n_m[i] = 0; err_m[i] = 0; cnt_m[i] = 0;
      end else begin
        if (!ex[4] && cnt_m[i] < cmax[i]) cnt_m[i]++;
        if (!err_m[i]) begin
          if (dcache) begin
            n_m[i]++;
            if (n_m[i] == wmax[i] - 1) err_m[i] = 1;
          end else begin
            n_m[i] = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                        input bit mr, input bit dc, input bit br);
    id_rs = rs; id_rt = rt; ex_rt = xrt; memread = mr; dcache = dc; branch = br;
  endtask

  initial begin
    int burst;
    wmax[0] = 256; wmax[1] = 8;
    cmax[0] = 65535; cmax[1] = 15;
    for (int i = 0; i < 2; i++) begin
      n_m[i] = 0; err_m[i] = 0; cnt_m[i] = 0;
    end
    //            r  rs  rt  xrt mr dc br  expected
    tab[0]  = '{0, 1,  2,  3,  0, 0, 0, 5'b11000};
    tab[1]  = '{0, 1,  5,  5,  1, 0, 0, 5'b00010};
    tab[2]  = '{0, 1,  5,  3,  0, 0, 0, 5'b11000};
    tab[3]  = '{0, 0,  0,  0,  1, 0, 0, 5'b11000};
    tab[4]  = '{0, 7,  2,  7,  1, 0, 0, 5'b00010};
    tab[5]  = '{0, 7,  2,  7,  0, 0, 0, 5'b11000};
    tab[6]  = '{0, 1,  2,  3,  0, 0, 1, 5'b11100};
    tab[7]  = '{0, 9,  2,  9,  1, 0, 1, 5'b00010};
    tab[8]  = '{0, 1,  2,  3,  0, 1, 0, 5'b00001};
    tab[9]  = '{0, 4,  2,  4,  1, 1, 1, 5'b00001};
    tab[10] = '{1, 4,  2,  4,  1, 0, 1, 5'b00010};
    tab[11] = '{0, 4,  5,  3,  1, 0, 0, 5'b11000};

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    step(1, 5'b00010, 1'b0);
    rst = 1'b0;
    step(1, 5'b11000, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rst = tab[i].r;
      set_in(tab[i].rs, tab[i].rt, tab[i].xrt, tab[i].mr, tab[i].dc, tab[i].br);
      step(1, tab[i].e, 1'b0);
    end
    rst = 1'b0;

    // Ten-cycle dcache miss on the deep-watchdog instance
    set_in(1, 2, 3, 0, 1, 0);
    repeat (10) step(1, 5'b00001, 1'b0);
    dcache = 1'b0;
    step(1, 5'b11000, 1'b0);
    rst = 1'b1;
    step(1, 5'b00010, 1'b0);
    rst = 1'b0;

    // Miss with concurrent load-use and branch, then release
    set_in(1, 5, 5, 1, 1, 1);
    repeat (3) step(1, 5'b00001, 1'b0);
    dcache = 1'b0;
    step(1, 5'b00010, 1'b0);
    memread = 1'b0;
    step(1, 5'b11100, 1'b0);
    branch = 1'b0;

    // Load-use bubble is a single cycle
    set_in(1, 5, 5, 1, 0, 0);
    step(1, 5'b00010, 1'b0);
    memread = 1'b0;
    step(1, 5'b11000, 1'b0);

    // Watchdog timeout on WAIT_MAX=8 instance
    rst = 1'b1;
    step(2, 5'b00010, 1'b0);
    rst = 1'b0;
    set_in(1, 2, 3, 0, 1, 0);
    for (int k = 1; k <= 20; k++) step(2, 5'b00001, (k >= 8));
    set_in(1, 2, 3, 0, 0, 1);
    repeat (3) step(2, 5'b00001, 1'b1);
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt_saturated", 32'(cnt_b), 32'd15);
`endif
    rst = 1'b1;
    step(2, 5'b00010, 1'b0);
    rst = 1'b0;
    branch = 1'b0;
    step(2, 5'b11000, 1'b0);

    // Reset during MEM_WAIT
    dcache = 1'b1;
    repeat (4) step(1, 5'b00001, 1'b0);
    rst = 1'b1;
    step(1, 5'b00010, 1'b0);
    rst = 1'b0;
    dcache = 1'b0;
    step(1, 5'b11000, 1'b0);

    // Randomized traffic with bursty dcache misses and occasional resets
    burst = 0;
    for (int t = 0; t < 2000; t++) begin
      id_rs   = 5'($urandom_range(0, 3));
      id_rt   = 5'($urandom_range(0, 3));
      ex_rt   = 5'($urandom_range(0, 3));
      memread = ($urandom_range(0, 2) == 0);
      branch  = ($urandom_range(0, 3) == 0);
      if (burst > 0) begin
        dcache = 1'b1;
        burst--;
      end else if ($urandom_range(0, 7) == 0) begin
        dcache = 1'b1;
        burst = $urandom_range(0, 11);
      end else begin
        dcache = 1'b0;
      end
      rst = ($urandom_range(0, 49) == 0);
      step(0, 5'b00000, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
